// File: rtl/oric_mem_pkg.sv
// Shared types for the toggle-handshake memory responder and its block RAM.
package oric_mem_pkg;

    localparam int WORD_W = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } resp_state_t;

    typedef enum logic {
        PORT1 = 1'b0,
        PORT2 = 1'b1
    } port_id_t;

endpackage

// File: rtl/toggle_port_responder_if.sv
// Two-port toggle-handshake memory bus: requesters drive req/a/ds/we/d, the responder returns ack/q/busy.
interface toggle_port_responder_if #(
    parameter int AW = 16
);
    import oric_mem_pkg::*;

    logic              port1_req;
    logic              port1_ack;
    logic [AW-1:0]     port1_a;
    logic [1:0]        port1_ds;
    logic              port1_we;
    logic [WORD_W-1:0] port1_d;
    logic [WORD_W-1:0] port1_q;

    logic              port2_req;
    logic              port2_ack;
    logic [AW-1:0]     port2_a;
    logic [1:0]        port2_ds;
    logic              port2_we;
    logic [WORD_W-1:0] port2_d;
    logic [WORD_W-1:0] port2_q;

    logic              busy;

    modport master (
        output port1_req, port1_a, port1_ds, port1_we, port1_d,
        output port2_req, port2_a, port2_ds, port2_we, port2_d,
        input  port1_ack, port1_q, port2_ack, port2_q, busy
    );

    modport slave (
        input  port1_req, port1_a, port1_ds, port1_we, port1_d,
        input  port2_req, port2_a, port2_ds, port2_we, port2_d,
        output port1_ack, port1_q, port2_ack, port2_q, busy
    );

endinterface

// File: rtl/toggle_resp_bram.sv
// Single-port 2^(AW-1) x 16 RAM with byte-lane write enables and a registered read per requester port.
module toggle_resp_bram
    import oric_mem_pkg::*;
#(
    parameter int AW = 16
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              i_rd,
    input  logic              i_wr,
    input  logic [1:0]        i_be,
    input  port_id_t          i_port,
    input  logic [AW-2:0]     i_addr,
    input  logic [WORD_W-1:0] i_wdata,
    output logic [WORD_W-1:0] o_q1,
    output logic [WORD_W-1:0] o_q2
);

    localparam int DEPTH = 1 << (AW - 1);

    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [WORD_W-1:0] r_q1;
    logic [WORD_W-1:0] r_q2;

    // NOTE: the array carries no reset so it can map onto block RAM; only the read registers are reset.
    always_ff @(posedge clk_sys) begin
        if (i_wr) begin
            if (i_be[0]) r_mem[i_addr][7:0]  <= i_wdata[7:0];
            if (i_be[1]) r_mem[i_addr][15:8] <= i_wdata[15:8];
        end
    end

    // Each port keeps its last read word until that port reads again.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_q1 <= '0;
            r_q2 <= '0;
        end else if (i_rd) begin
            if (i_port == PORT1) r_q1 <= r_mem[i_addr];
            else                 r_q2 <= r_mem[i_addr];
        end
    end

    assign o_q1 = r_q1;
    assign o_q2 = r_q2;

endmodule

// File: rtl/toggle_port_responder.sv
// Toggle-handshake responder: round-robin arbiter plus fixed-latency access into an on-chip RAM.
// Optional macro TOGGLE_RESP_ROM_PROTECT_EN blocks writes at or above ROM_BASE.
module toggle_port_responder
    import oric_mem_pkg::*;
#(
    parameter int          AW       = 16,
    parameter int          LATENCY  = 2,
    parameter logic [15:0] ROM_BASE = 16'hC000
) (
    input  logic                   clk_sys,
    input  logic                   reset_n,
    toggle_port_responder_if.slave bus
);

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    if (LATENCY < 1 || LATENCY > 15 || 32'(ROM_BASE) >= (32'd1 << AW)) begin : g_bad_cfg
        $error("toggle_port_responder: LATENCY must be 1..15 and ROM_BASE inside the address space");
    end

    resp_state_t       r_state;
    port_id_t          r_last_grant;
    logic [3:0]        r_cnt;
    logic [AW-2:0]     r_word;
    logic [1:0]        r_ds;
    logic              r_we;
    logic [WORD_W-1:0] r_d;
    logic              r_ack1;
    logic              r_ack2;
    logic              r_busy;

    logic w_pend1;
    logic w_pend2;
    logic w_pick2;
    logic w_done;
    logic w_wr_block;

    assign w_pend1 = bus.port1_req ^ r_ack1;
    assign w_pend2 = bus.port2_req ^ r_ack2;
    // Port 2 wins only when port 1 is idle or port 1 was the last one served.
    assign w_pick2 = w_pend2 && (!w_pend1 || r_last_grant == PORT1);
    assign w_done  = (r_state == ACCESS) && (r_cnt == 4'd0);

`ifdef TOGGLE_RESP_ROM_PROTECT_EN
    localparam logic [AW-1:0] ROM_BASE_A = AW'(ROM_BASE);
    logic r_rom;
    assign w_wr_block = r_rom;
`else
    assign w_wr_block = 1'b0;
`endif

    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_last_grant <= PORT2;
            r_cnt        <= '0;
            r_word       <= '0;
            r_ds         <= '0;
            r_we         <= 1'b0;
            r_d          <= '0;
            r_ack1       <= 1'b0;
            r_ack2       <= 1'b0;
            r_busy       <= 1'b0;
`ifdef TOGGLE_RESP_ROM_PROTECT_EN
            r_rom        <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pend1 || w_pend2) begin
                        r_last_grant <= w_pick2 ? PORT2 : PORT1;
                        r_word       <= w_pick2 ? bus.port2_a[AW-1:1] : bus.port1_a[AW-1:1];
                        r_ds         <= w_pick2 ? bus.port2_ds : bus.port1_ds;
                        r_we         <= w_pick2 ? bus.port2_we : bus.port1_we;
                        r_d          <= w_pick2 ? bus.port2_d  : bus.port1_d;
`ifdef TOGGLE_RESP_ROM_PROTECT_EN
                        r_rom        <= (w_pick2 ? bus.port2_a : bus.port1_a) >= ROM_BASE_A;
`endif
                        r_cnt        <= CNT_LOAD;
                        r_busy       <= 1'b1;
                        r_state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        if (r_last_grant == PORT1) r_ack1 <= ~r_ack1;
                        else                       r_ack2 <= ~r_ack2;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    toggle_resp_bram #(
        .AW (AW)
    ) u_bram (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .i_rd    (w_done && !r_we),
        .i_wr    (w_done && r_we && !w_wr_block),
        .i_be    (r_ds),
        .i_port  (r_last_grant),
        .i_addr  (r_word),
        .i_wdata (r_d),
        .o_q1    (bus.port1_q),
        .o_q2    (bus.port2_q)
    );

    assign bus.port1_ack = r_ack1;
    assign bus.port2_ack = r_ack2;
    assign bus.busy      = r_busy;

endmodule

// File: tb/tb_toggle_port_responder.sv
// Scoreboard bench for toggle_port_responder: a word-level memory model predicts q and ack timing per port.
`timescale 1ns/1ps
module tb_toggle_port_responder;
    import oric_mem_pkg::*;

    localparam int AW  = 16;
    localparam int LAT = 2;

    typedef struct packed {
        logic [15:0] a;
        logic [1:0]  ds;
        logic        we;
        logic [15:0] d;
    } txn_t;

    typedef struct {
        logic [15:0] exp_q;
        logic [15:0] mask;
        int          exp_cyc;
        string       tag;
    } sb_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    toggle_port_responder_if #(.AW(AW)) bus ();

    toggle_port_responder #(
        .AW      (AW),
        .LATENCY (LAT)
    ) dut (
        .clk_sys (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: word-addressed memory with per-lane "known" flags, per-port q, last-served port.
    logic [15:0] mdl_mem   [int];
    logic [1:0]  mdl_known [int];
    logic [15:0] mdl_q     [2];
    logic [15:0] mdl_qmask [2];
    int          mdl_last;
    sb_t         sbq1 [$];
    sb_t         sbq2 [$];
    bit          mon_en = 1'b0;
    logic        prev_ack1 = 1'b0;
    logic        prev_ack2 = 1'b0;
    logic [15:0] pool [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] lane_bits(input logic [1:0] m);
        return {{8{m[1]}}, {8{m[0]}}};
    endfunction

    task automatic mdl_apply(input int p, input txn_t t, input int exp_cyc, input string tag);
        int          w;
        sb_t         e;
        logic [15:0] word;
        logic [1:0]  kn;
        bit          rom;
        w    = int'(t.a[15:1]);
        word = mdl_mem.exists(w) ? mdl_mem[w] : 16'h0000;
        kn   = mdl_known.exists(w) ? mdl_known[w] : 2'b00;
`ifdef TOGGLE_RESP_ROM_PROTECT_EN
        rom = (t.a >= 16'hC000);
`else
        rom = 1'b0;
`endif
        if (t.we) begin
            if (!rom) begin
                for (int i = 0; i < 2; i++) begin
                    if (t.ds[i]) begin
                        word[i*8 +: 8] = t.d[i*8 +: 8];
                        kn[i]          = 1'b1;
                    end
                end
                mdl_mem[w]   = word;
                mdl_known[w] = kn;
            end
        end else begin
            mdl_q[p]     = word;
            mdl_qmask[p] = lane_bits(kn);
        end
        e.exp_q   = mdl_q[p];
        e.mask    = mdl_qmask[p];
        e.exp_cyc = exp_cyc;
        e.tag     = tag;
        if (p == 0) sbq1.push_back(e);
        else        sbq2.push_back(e);
    endtask

    task automatic mon_port(input int p, input logic [15:0] q);
        sb_t e;
        int  depth;
        depth = (p == 0) ? sbq1.size() : sbq2.size();
        if (depth == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_ack_p%0d at cycle %0d", p + 1, cyc);
            return;
        end
        if (p == 0) e = sbq1.pop_front();
        else        e = sbq2.pop_front();
        check($sformatf("%s_latency_p%0d", e.tag, p + 1), cyc, e.exp_cyc);
        if (e.mask != 16'h0000)
            check($sformatf("%s_q_p%0d", e.tag, p + 1), q & e.mask, e.exp_q & e.mask);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.port1_ack != prev_ack1) mon_port(0, bus.port1_q);
            if (bus.port2_ack != prev_ack2) mon_port(1, bus.port2_q);
        end
        prev_ack1 <= bus.port1_ack;
        prev_ack2 <= bus.port2_ack;
    end

    function automatic txn_t rand_txn();
        txn_t t;
        t.a  = pool[$urandom_range(0, 7)] | 16'($urandom_range(0, 1));
        t.ds = 2'($urandom_range(0, 3));
        t.we = 1'($urandom_range(0, 1));
        t.d  = 16'($urandom);
        return t;
    endfunction

    task automatic drive(input int p, input txn_t t);
        if (p == 0) begin
            bus.port1_a = t.a; bus.port1_ds = t.ds; bus.port1_we = t.we; bus.port1_d = t.d;
            bus.port1_req = ~bus.port1_req;
        end else begin
            bus.port2_a = t.a; bus.port2_ds = t.ds; bus.port2_we = t.we; bus.port2_d = t.d;
            bus.port2_req = ~bus.port2_req;
        end
    endtask

    // Change the request fields after grant; the responder must ignore them.
    task automatic scramble(input int p);
        txn_t r;
        r = rand_txn();
        if (p == 0) begin
            bus.port1_a = r.a; bus.port1_ds = r.ds; bus.port1_we = r.we; bus.port1_d = r.d;
        end else begin
            bus.port2_a = r.a; bus.port2_ds = r.ds; bus.port2_we = r.we; bus.port2_d = r.d;
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((sbq1.size() + sbq2.size()) != 0 && n < 64) begin
            @(posedge clk);
            n++;
        end
        if ((sbq1.size() + sbq2.size()) != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_timeout: pending p1=%0d p2=%0d", tag, sbq1.size(), sbq2.size());
            sbq1.delete();
            sbq2.delete();
        end
    endtask

    // The port not served most recently goes first when both are pending.
    task automatic issue(input bit u1, input bit u2, input txn_t t1, input txn_t t2,
                         input string tag, input bit do_wait);
        int base;
        @(posedge clk);
        #1;
        base = cyc;
        if (u1 && u2) begin
            if (mdl_last == 1) begin
                mdl_apply(0, t1, base + 1 + LAT, tag);
                mdl_apply(1, t2, base + 2 * (1 + LAT), tag);
                mdl_last = 1;
            end else begin
                mdl_apply(1, t2, base + 1 + LAT, tag);
                mdl_apply(0, t1, base + 2 * (1 + LAT), tag);
                mdl_last = 0;
            end
        end else if (u1) begin
            mdl_apply(0, t1, base + 1 + LAT, tag);
            mdl_last = 0;
        end else if (u2) begin
            mdl_apply(1, t2, base + 1 + LAT, tag);
            mdl_last = 1;
        end
        if (u1) drive(0, t1);
        if (u2) drive(1, t2);
        if (u1 ^ u2) begin
            @(posedge clk);
            #1;
            scramble(u1 ? 0 : 1);
        end
        if (do_wait) wait_idle(tag);
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        rst_n  = 1'b0;
        bus.port1_req = 1'b0; bus.port1_a = '0; bus.port1_ds = '0; bus.port1_we = 1'b0; bus.port1_d = '0;
        bus.port2_req = 1'b0; bus.port2_a = '0; bus.port2_ds = '0; bus.port2_we = 1'b0; bus.port2_d = '0;
        sbq1.delete();
        sbq2.delete();
        mdl_q[0] = 16'h0000; mdl_q[1] = 16'h0000;
        mdl_qmask[0] = 16'hFFFF; mdl_qmask[1] = 16'hFFFF;
        mdl_last = 1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
    endtask

    initial begin
        txn_t        t1;
        txn_t        t2;
        txn_t        z;
        int          kind;
        int          nb;
        logic [15:0] old_w;

        z = '0;
        pool[0] = 16'h0000; pool[1] = 16'h0400; pool[2] = 16'h0402; pool[3] = 16'h1000;
        pool[4] = 16'h2ABC; pool[5] = 16'h5550; pool[6] = 16'h7FFE; pool[7] = 16'hBFFE;

        do_reset();
        check("reset_ack1", bus.port1_ack, 1'b0);
        check("reset_ack2", bus.port2_ack, 1'b0);
        check("reset_q1",   bus.port1_q,   16'h0000);
        check("reset_q2",   bus.port2_q,   16'h0000);
        check("reset_busy", bus.busy,      1'b0);

        // Simultaneous requests after reset: port 1 acked at +3, port 2 at +6.
        t1 = '{a: 16'h0400, ds: 2'b01, we: 1'b1, d: 16'h00A5};
        t2 = '{a: 16'h0401, ds: 2'b10, we: 1'b1, d: 16'h3C00};
        issue(1'b1, 1'b1, t1, t2, "pair_wr", 1'b1);
        t1 = '{a: 16'h0400, ds: 2'b00, we: 1'b0, d: 16'h0000};
        issue(1'b1, 1'b0, t1, z, "rd_0400", 1'b1);
        check("rd_0400_value", bus.port1_q, 16'h3CA5);

        for (int n = 0; n < 3; n++) begin
            t2 = '{a: 16'h0401, ds: 2'b11, we: 1'b0, d: 16'h0000};
            issue(1'b1, 1'b1, t1, t2, "rr_pair", 1'b1);
        end

        // Empty lane mask: ack still toggles, busy high for LAT cycles, RAM untouched.
        t1 = '{a: 16'h0400, ds: 2'b00, we: 1'b1, d: 16'hFFFF};
        issue(1'b1, 1'b0, t1, z, "ds00", 1'b0);
        nb = 0;
        repeat (LAT + 2) begin
            @(negedge clk);
            if (bus.busy) nb++;
        end
        check("ds00_busy_cycles", nb, LAT);
        wait_idle("ds00");
        t2 = '{a: 16'h0400, ds: 2'b11, we: 1'b0, d: 16'h0000};
        issue(1'b0, 1'b1, z, t2, "ds00_rd", 1'b1);

        for (int n = 0; n < 8; n++) begin
            t1 = '{a: pool[n], ds: 2'b11, we: 1'b1, d: 16'($urandom)};
            issue(1'b1, 1'b0, t1, z, "init", 1'b1);
        end

        for (int n = 0; n < 200; n++) begin
            kind = $urandom_range(0, 2);
            t1   = rand_txn();
            t2   = rand_txn();
            issue(kind != 1, kind != 0, t1, t2, "rand", 1'b1);
        end

        t1 = '{a: 16'hC123, ds: 2'b11, we: 1'b1, d: 16'hFFFF};
        issue(1'b1, 1'b0, t1, z, "rom_wr", 1'b1);
        t1 = '{a: 16'hC123, ds: 2'b11, we: 1'b0, d: 16'h0000};
        issue(1'b1, 1'b0, t1, z, "rom_rd", 1'b1);

        // Reset one cycle after a write grant: nothing may be committed.
        old_w = mdl_mem[int'(16'h1000 >> 1)];
        t1 = '{a: 16'h1000, ds: 2'b11, we: 1'b1, d: ~old_w};
        @(posedge clk);
        #1;
        drive(0, t1);
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("midrst_ack1", bus.port1_ack, 1'b0);
        check("midrst_ack2", bus.port2_ack, 1'b0);
        check("midrst_q1",   bus.port1_q,   16'h0000);
        check("midrst_q2",   bus.port2_q,   16'h0000);
        check("midrst_busy", bus.busy,      1'b0);
        do_reset();
        t2 = '{a: 16'h1000, ds: 2'b11, we: 1'b0, d: 16'h0000};
        issue(1'b0, 1'b1, z, t2, "midrst_rd", 1'b1);
        check("midrst_word_kept", bus.port2_q, old_w);

        repeat (4) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/toggle_port_responder.md
Name: toggle_port_responder

Overview:
- Responder end of the two-port toggle-handshake memory interface (portN_req/portN_ack/a/ds/we/d/q) driven by the machine top level and the FDC.
- Backs both ports with one on-chip 16-bit-wide block RAM, so the core can run without SDRAM in simulation and in small builds.
- Arbitrates between the two requesters, performs a byte-lane-masked access after a fixed wait-state latency, then toggles the matching ack.

Parameters:
- AW, 16, byte address width; the RAM holds 2^(AW-1) 16-bit words, indexed by a[AW-1:1].
- LATENCY, 2, cycles from grant to completion; legal range 1..15.
- ROM_BASE, 16'hC000, first byte address of the write-protected region (used only with the optional feature).

Ports:
- clk_sys  in  1  system clock; all logic rises on it.
- reset_n  in  1  asynchronous, active-low reset.
- port1_req  in  1  port 1 request toggle.
- port1_ack  out  1  port 1 acknowledge toggle.
- port1_a  in  AW  port 1 byte address.
- port1_ds  in  2  port 1 byte-lane enables, [1]=d[15:8], [0]=d[7:0].
- port1_we  in  1  port 1 write when 1, read when 0.
- port1_d  in  16  port 1 write data.
- port1_q  out  16  port 1 read data, full word.
- port2_req, port2_ack, port2_a, port2_ds, port2_we, port2_d, port2_q: same as port 1, for port 2.
- busy  out  1  high while in ACCESS.

Behaviour:
- Pending condition: portN is pending while portN_req != portN_ack. The requester must not toggle req again until ack matches. A double toggle is invisible to the responder and is a protocol violation.
- Reset values: port1_ack=0, port2_ack=0, port1_q=0, port2_q=0, busy=0, state=IDLE, last_grant=2 (so port 1 wins the first contention). RAM contents are not reset.
- State machine states: IDLE, ACCESS.
- IDLE:
  - Neither port pending: stay in IDLE.
  - One port pending: grant it.
  - Both pending: grant the port != last_grant (round-robin).
  - On grant: latch a, ds, we and d of the granted port; set last_grant; load cnt=LATENCY-1; go to ACCESS; busy=1.
- ACCESS:
  - While cnt != 0, decrement cnt.
  - On the cnt==0 cycle, write: RAM word a[AW-1:1] lane i takes d lane i where ds[i]=1. ds=00 writes nothing but still acks.
  - On the cnt==0 cycle, read: qN <= RAM word (registered read, full 16 bits regardless of ds).
  - On the same edge, toggle ackN, clear busy, return to IDLE.
- Latency: req toggles at edge k; grant at edge k+1; ack toggle and q valid at edge k+1+LATENCY. Back-to-back grants are possible: IDLE lasts one cycle between accesses.
- qN holds its value until the next read on that port. Writes never modify q.
- Latched fields are sampled only at grant. Input changes during ACCESS have no effect.
- A request arriving on the other port during ACCESS waits. The port that was just served cannot re-win against a pending other port.
- Address wrap: upper address bits beyond AW do not exist. a[0] is ignored for word selection; the requester selects the lane via ds.
- Reset asserted mid-ACCESS: the access is abandoned. No write is committed unless the completion edge already occurred. Acks return to 0, so requesters must also be reset.
- Read and write to the same word at the same cycle cannot happen, because there is a single access path.

Optional Feature:
- Macro: TOGGLE_RESP_ROM_PROTECT_EN.
- With the macro defined: writes with latched a >= ROM_BASE commit nothing, but still take LATENCY cycles and toggle ack. Reads are unaffected.
- Without the macro: ROM_BASE is unused and all addresses are writable.

Decomposition:
- Shared package oric_mem_pkg:
  - typedef resp_state_t {IDLE, ACCESS}.
  - typedef port_id_t (1-bit: 0=port 1, 1=port 2).
  - localparam WORD_W=16.
- One sub-module: toggle_resp_bram (single-port, byte-enable-write, registered-read RAM, 2^(AW-1) x 16).
- Arbitration, latches and the FSM stay in the top.

Test Plan:
- Reset, then port 1 writes a=16'h0400, ds=01, d=16'h00A5 -> port1_ack toggles 3 cycles after the req toggle (LATENCY=2). A subsequent read of a=16'h0400 returns q[7:0]=8'hA5 and upper lane unchanged.
- Port 2 writes a=16'h0401, ds=10, d=16'h3C00; port 1 reads a=16'h0400 -> port1_q=16'h3CA5.
- Both reqs toggled on the same edge after reset -> port 1 is granted first (ack at +3), port 2 is acked at +6. Repeat while both are pending -> grants alternate.
- Port 1 write with ds=00 -> ack toggles, RAM unchanged, busy pulses for LATENCY cycles.
- With TOGGLE_RESP_ROM_PROTECT_EN, write a=16'hC123, d=16'hFFFF -> ack toggles, readback shows the old value. Without the macro, readback shows 16'hFFFF.
- Assert reset_n=0 one cycle after a write grant -> both acks=0, q=0, busy=0, and the target word is unchanged after reset release.
